// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM encoding and default width for the serial subtractor
// Purpose: FSM state type and default operand width used by serial_subtractor.
// Ports: none (package).
package serial_sub_pkg;

  localparam int SERIAL_SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_half_sub.sv
// rtl/serial_subtractor_half_sub.sv - combinational half subtractor (module half_sub)
// Purpose: one-bit x - y without borrow-in.
// Ports:
//   x  - minuend bit
//   y  - subtrahend bit
//   d  - difference bit, x ^ y
//   bo - borrow out, ~x & y
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b subtractor, LSB first, one bit per clock
// Purpose: on an accepted start, subtracts b from a over WIDTH SHIFT cycles and
//   presents the registered result with a one-cycle done pulse.
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to add the signed overflow output.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - subtract request, sampled only while ready=1
//   a, b       - minuend / subtrahend, captured on an accepted start
//   ready      - high only in IDLE
//   diff       - registered a-b mod 2^WIDTH, held until the next completion
//   borrow_out - final borrow, 1 iff a < b unsigned
//   done       - one-cycle pulse, diff/borrow_out valid
//   overflow   - (SERIAL_SUB_OVERFLOW_EN only) signed a-b not representable
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             done
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             borrow_q;
  logic [CW-1:0]    cnt;
  logic             last_shift;

  logic             d1;
  logic             bo1;
  logic             d_bit;
  logic             bo2;
  logic             bout;

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Operand sign bits are shifted out of a_sr/b_sr, so keep them separately.
  logic             a_sign;
  logic             b_sign;
`endif

  // Full subtractor: (a - b) then minus the running borrow.
  half_sub u_hs1 (.x(a_sr[0]), .y(b_sr[0]), .d(d1),    .bo(bo1));
  half_sub u_hs2 (.x(d1),      .y(borrow_q), .d(d_bit), .bo(bo2));
  assign bout = bo1 | bo2;

  assign res_nxt    = {d_bit, res_sr[WIDTH-1:1]};
  assign last_shift = (state == SHIFT) && (cnt == LAST_CNT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  // Datapath. The result registers are written on the edge that enters DONE,
  // using the final shift's value, so they are already valid while done=1
  // and stay untouched through later SHIFT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow_q   <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_sign     <= 1'b0;
      b_sign     <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            res_sr   <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_sign   <= a[WIDTH-1];
            b_sign   <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          res_sr   <= res_nxt;
          borrow_q <= bout;
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          cnt      <= cnt + CW'(1);
          if (last_shift) begin
            diff       <= res_nxt;
            borrow_out <= bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // d_bit on the last shift is the result sign bit.
            overflow   <= (a_sign != b_sign) && (d_bit != a_sign);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         done;
  logic         overflow;

  int checks;
  int errors;
  int done_cnt;
  logic [W-1:0] last_diff;
  exp_t sb[$];
  vec_t vecs[9];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .ready(ready),
    .diff(diff),
    .borrow_out(borrow_out),
    .done(done)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

`ifndef SERIAL_SUB_OVERFLOW_EN
  assign overflow = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got diff %0h want no done", diff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", diff, e.diff);
        check("borrow_out", borrow_out, e.borrow);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("overflow", overflow, e.ovf);
`endif
        last_diff = e.diff;
      end
    end
  end

  // Called on a negedge. Drives one operation and checks latency, hold and ready.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input exp_t e);
    int w;
    int lat;
    w = 0;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", ready, 1'b1);
    a = ta;
    b = tb_;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ta;
    b = W'($urandom);
    for (lat = 0; lat < 40; lat++) begin
      @(negedge clk);
      if (done) break;
      if (lat == 3) begin
        check("hold_diff", diff, last_diff);
        check("busy_ready", ready, 1'b0);
      end
    end
    check("latency", lat, W);
    @(negedge clk);
    check("ready_back", ready, 1'b1);
    check("done_low", done, 1'b0);
  endtask

  initial begin
    int base;
    int w;
    exp_t e;
    checks = 0;
    errors = 0;
    done_cnt = 0;
    last_diff = '0;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};
    vecs[7] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
    vecs[8] = '{8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_borrow", borrow_out, 1'b0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("rst_overflow", overflow, 1'b0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      e = '{vecs[i].diff, vecs[i].borrow, vecs[i].ovf};
      run_op(vecs[i].a, vecs[i].b, e);
    end

    // Busy: start held 12 edges; a/b switch to 1/1 after the first edge.
    // The in-flight op keeps 9-4; the held start is re-accepted once ready returns.
    @(negedge clk);
    base = done_cnt;
    a = 8'h09;
    b = 8'h04;
    start = 1'b1;
    sb.push_back('{8'h05, 1'b0, 1'b0});
    sb.push_back('{8'h00, 1'b0, 1'b0});
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        a = 8'h01;
        b = 8'h01;
      end
    end
    start = 1'b0;
    w = 0;
    while ((sb.size() != 0 || !ready) && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("busy_drained", sb.size(), 0);
    check("busy_done_count", done_cnt - base, 2);

    // Reset during the 4th SHIFT cycle.
    @(negedge clk);
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    sb.push_back('{8'h22, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    base = done_cnt;
    rst_n = 1'b0;
    sb.delete();
    last_diff = '0;
    #1;
    check("midrst_ready", ready, 1'b1);
    check("midrst_done", done, 1'b0);
    check("midrst_diff", diff, 8'h00);
    check("midrst_borrow", borrow_out, 1'b0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("midrst_overflow", overflow, 1'b0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h01, '{8'h0F, 1'b0, 1'b0});
    check("midrst_single_done", done_cnt - base, 1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
